// File: rtl/bcd_to_bin_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_if
// Bundles the request/result signals of the BCD-to-binary converter.
//
// Handshake: the requester drives bcd and pulses start; start is taken only
// when the converter is idle and en=1 (there is no back-pressure signal and
// no queuing, so a start seen while busy or during done is dropped). busy
// is high for the whole conversion. done is a one-clock pulse, and bin and
// invalid are valid from that cycle until the next conversion completes.
//
// Signals:
//   en      : clock enable for acceptance and conversion steps
//   start   : conversion request
//   bcd     : packed BCD operand, digit [0] least significant
//   busy    : conversion in progress
//   done    : one-clock completion pulse
//   invalid : last accepted operand held a digit above 9
//   bin     : binary result, zero-extended
// Modports: master (requester), slave (converter).
// ---------------------------------------------------------------------------
interface bcd_to_bin_if #(
    parameter int BCD_DIGITS = 2
) ();
    logic                          en;
    logic                          start;
    logic [BCD_DIGITS-1:0][3:0]    bcd;
    logic                          busy;
    logic                          done;
    logic                          invalid;
    logic [4*BCD_DIGITS-1:0]       bin;

    modport master (
        output en, start, bcd,
        input  busy, done, invalid, bin
    );

    modport slave (
        input  en, start, bcd,
        output busy, done, invalid, bin
    );
endinterface

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
// Sequential BCD-to-binary converter (reverse double dabble), one bit per
// enabled clock. A legal operand takes 4*BCD_DIGITS steps. An operand with a
// digit above 9 skips conversion and reports invalid with bin=0.
//
// Ports:
//   clk       : clock, all state updates on posedge
//   arst_n    : synchronous active-low reset
//   bus       : bcd_to_bin_if slave (en, start, bcd -> busy, done, invalid, bin)
//   fsm_state : current FSM state (0 IDLE, 1 CONVERT, 2 DONE) for observation
// ---------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int BCD_DIGITS = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    bcd_to_bin_if.slave bus,
    output logic [1:0]  fsm_state
);
    localparam int W  = 4 * BCD_DIGITS;
    // Counter must reach W itself without wrapping.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_bcd_q, shift_bcd_d;
    logic [W-1:0]  shift_bin_q, shift_bin_d;
    logic [W-1:0]  step_bcd, step_bin;
    logic [W-1:0]  bin_q, bin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          invalid_q, invalid_d;
    logic          operand_bad;

    // One conversion step: shift the combined register right, then pull
    // every BCD digit that became >=8 back down by 3 (undoes the x10 weight
    // a bit gets when it crosses from one digit into the one below).
    always_comb begin
        {step_bcd, step_bin} = {shift_bcd_q, shift_bin_q} >> 1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (step_bcd[4*i +: 4] >= 4'd8) begin
                step_bcd[4*i +: 4] = step_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        operand_bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bus.bcd[i] > 4'd9) begin
                operand_bad = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. bin/invalid only move on the edge
    // that enters DONE, so they stay frozen throughout CONVERT.
    always_comb begin
        state_d     = state_q;
        shift_bcd_d = shift_bcd_q;
        shift_bin_d = shift_bin_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        invalid_d   = invalid_q;

        case (state_q)
            IDLE: begin
                if (bus.en && bus.start) begin
                    shift_bcd_d = bus.bcd;
                    shift_bin_d = '0;
                    cnt_d       = '0;
                    if (operand_bad) begin
                        state_d   = DONE;
                        invalid_d = 1'b1;
                        bin_d     = '0;
                    end else begin
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                if (bus.en) begin
                    shift_bcd_d = step_bcd;
                    shift_bin_d = step_bin;
                    cnt_d       = cnt_q + 1'b1;
                    // The final step's result goes straight to bin so done
                    // rises on the same edge as the last shift.
                    if (cnt_q == CW'(W - 1)) begin
                        state_d   = DONE;
                        bin_d     = step_bin;
                        invalid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CONVERT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            shift_bcd_q <= '0;
            shift_bin_q <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            invalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_bcd_q <= shift_bcd_d;
            shift_bin_q <= shift_bin_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            invalid_q   <= invalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.invalid = invalid_q;
    assign bus.bin     = bin_q;
    assign fsm_state   = state_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
// Directed bench for bcd_to_bin with two instances: BCD_DIGITS=2 for the
// protocol cases (latency, invalid operands, ignored starts, en stalls,
// mid-conversion reset) and BCD_DIGITS=3 for a full 000..999 sweep.
// Expected {invalid, bin} values are pushed when a start is driven and popped
// by a monitor when done is seen.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    bcd_to_bin_if #(.BCD_DIGITS(2)) bus2 ();
    bcd_to_bin_if #(.BCD_DIGITS(3)) bus3 ();
    logic [1:0] st2, st3;

    bcd_to_bin #(.BCD_DIGITS(2)) dut2 (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (bus2),
        .fsm_state (st2)
    );

    bcd_to_bin #(.BCD_DIGITS(3)) dut3 (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (bus3),
        .fsm_state (st3)
    );

    // ---------------- scoreboard ----------------
    logic [8:0]  exp_q2[$];
    logic [12:0] exp_q3[$];
    int n_vec = 0;
    int n_err = 0;
    int done_cnt2 = 0;
    int done_cnt3 = 0;
    int busy_cyc2 = 0;
    logic       prev_done2 = 1'b0;
    logic       prev_done3 = 1'b0;
    logic [8:0] prev_res2  = '0;

    function automatic logic [8:0] model2(input logic [7:0] b);
        if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return 9'h100;
        return {1'b0, 8'(int'(b[7:4]) * 10 + int'(b[3:0]))};
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (arst_n) begin
            if (bus2.busy) begin
                busy_cyc2++;
                n_vec++;
                assert ({bus2.invalid, bus2.bin} === prev_res2) else begin
                    n_err++;
                    $error("FAIL result_stable_in_convert: observed %0h expected %0h",
                           {bus2.invalid, bus2.bin}, prev_res2);
                end
            end
            if (bus2.done) begin
                done_cnt2++;
                n_vec++;
                assert (!prev_done2) else begin
                    n_err++;
                    $error("FAIL done_one_clock: observed done high 2 cycles expected 1");
                end
                n_vec++;
                assert (exp_q2.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_done2: observed done with empty queue expected none");
                end
                if (exp_q2.size() != 0) begin
                    e = exp_q2.pop_front();
                    n_vec++;
                    assert ({bus2.invalid, bus2.bin} === e) else begin
                        n_err++;
                        $error("FAIL result2: observed inv=%0b bin=%0d expected inv=%0b bin=%0d",
                               bus2.invalid, bus2.bin, e[8], e[7:0]);
                    end
                end
            end
        end
        prev_done2 = bus2.done;
        prev_res2  = {bus2.invalid, bus2.bin};
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (arst_n && bus3.done) begin
            done_cnt3++;
            n_vec++;
            assert (!prev_done3) else begin
                n_err++;
                $error("FAIL done3_one_clock: observed done high 2 cycles expected 1");
            end
            n_vec++;
            assert (exp_q3.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_done3: observed done with empty queue expected none");
            end
            if (exp_q3.size() != 0) begin
                e = exp_q3.pop_front();
                n_vec++;
                assert ({bus3.invalid, bus3.bin} === e) else begin
                    n_err++;
                    $error("FAIL result3: observed inv=%0b bin=%0d expected inv=%0b bin=%0d",
                           bus3.invalid, bus3.bin, e[12], e[11:0]);
                end
            end
        end
        prev_done3 = bus3.done;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit use3, input int limit, output int dcyc);
        dcyc = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ((use3 ? bus3.done : bus2.done) === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        n_vec++;
        assert (dcyc >= 0) else begin
            n_err++;
            $error("FAIL done_timeout: observed no done in %0d cycles expected done", limit);
        end
    endtask

    // Full transaction on the 2-digit instance with en held high.
    task automatic run2(input logic [7:0] b);
        logic [8:0] e;
        int a_cyc, d_cyc, b0, exp_lat;
        e = model2(b);
        exp_lat = e[8] ? 1 : 9;
        bus2.bcd   = b;
        bus2.start = 1'b1;
        exp_q2.push_back(e);
        b0 = busy_cyc2;
        tick();
        bus2.start = 1'b0;
        a_cyc = cyc;
        wait_done(1'b0, 30, d_cyc);
        if (d_cyc >= 0) chk("latency", d_cyc - a_cyc + 1, exp_lat);
        chk("busy_cycles", busy_cyc2 - b0, exp_lat - 1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a_cyc, d_cyc, d0;
        logic [7:0] rb;

        arst_n     = 1'b0;
        bus2.en    = 1'b0;
        bus2.start = 1'b0;
        bus2.bcd   = '0;
        bus3.en    = 1'b0;
        bus3.start = 1'b0;
        bus3.bcd   = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_busy", bus2.busy, 0);
        chk("reset_done", bus2.done, 0);
        chk("reset_invalid", bus2.invalid, 0);
        chk("reset_bin", bus2.bin, 0);
        chk("reset_state", st2, 0);
        chk("reset_bin3", bus3.bin, 0);
        tick();
        arst_n  = 1'b1;
        bus2.en = 1'b1;
        tick();

        // 99: 8 busy clocks, done at latency 9
        run2(8'h99);
        // invalid operand then a legal one
        run2(8'hA3);
        run2(8'h42);

        // second start during CONVERT is dropped
        bus2.bcd   = 8'h17;
        bus2.start = 1'b1;
        exp_q2.push_back(model2(8'h17));
        d0 = done_cnt2;
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        bus2.bcd   = 8'h55;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        @(negedge clk);
        chk("busy_mid_convert", bus2.busy, 1);
        chk("state_convert", st2, 1);
        wait_done(1'b0, 30, d_cyc);
        repeat (14) tick();
        chk("single_done", done_cnt2 - d0, 1);

        // random operands, some with illegal digits
        for (int i = 0; i < 8; i++) begin
            rb = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 12))};
            run2(rb);
        end

        // en low for 3 clocks mid-conversion adds 3 clocks of latency
        bus2.bcd   = 8'h63;
        bus2.start = 1'b1;
        exp_q2.push_back(model2(8'h63));
        tick();
        bus2.start = 1'b0;
        a_cyc = cyc;
        tick();
        tick();
        bus2.en = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("busy_while_stalled", bus2.busy, 1);
        bus2.en = 1'b1;
        wait_done(1'b0, 30, d_cyc);
        if (d_cyc >= 0) chk("latency_stalled", d_cyc - a_cyc + 1, 12);
        tick();

        // reset in the middle of converting 88
        bus2.bcd   = 8'h88;
        bus2.start = 1'b1;
        exp_q2.push_back(model2(8'h88));
        d0 = done_cnt2;
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        tick();
        arst_n = 1'b0;
        exp_q2.delete();
        tick();
        arst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", bus2.busy, 0);
        chk("rst_mid_bin", bus2.bin, 0);
        chk("rst_mid_done", bus2.done, 0);
        chk("rst_mid_state", st2, 0);
        repeat (14) tick();
        chk("no_done_after_reset", done_cnt2 - d0, 0);
        run2(8'h00);

        // exhaustive 3-digit sweep
        bus3.en = 1'b1;
        d0 = done_cnt3;
        for (int v = 0; v < 1000; v++) begin
            bus3.bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            bus3.start = 1'b1;
            exp_q3.push_back({1'b0, 12'(v)});
            tick();
            bus3.start = 1'b0;
            wait_done(1'b1, 30, d_cyc);
            tick();
        end
        chk("sweep_done_count", done_cnt3 - d0, 1000);
        chk("sweep_queue_empty", exp_q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule
